dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_line_ram.sv | 50 +++++
 rtl/dmem_responder.sv | 140 ++++++++++++++
 tb/tb_dmem_responder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared widths and FSM state type for the dual-port line data memory.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_pkg;

  localparam int LINE_W = 128;
  localparam int WORD_W = 32;
  localparam int LANES  = LINE_W / WORD_W;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

endpackage : dmem_pkg

// File: rtl/dmem_line_ram.sv
// Line storage: scalar side with per-lane write enables, vector side with a full-line write.
// Latency: 1 cycle read on both sides, read-first on a same-line write; scalar lanes win a same-line collision.
// Backpressure: none, one access per side per cycle.
//
// Ports:
//   clk          rising-edge clock
//   a_line_i     scalar-side line index      a_lane_we_i  per-lane write enables
//   a_wdata_i    scalar data (lane-replicated) a_rdata_o  registered full line
//   b_line_i     vector-side line index      b_we_i       full-line write enable
//   b_wdata_i    vector write data           b_rdata_o    registered full line
module dmem_line_ram
  import dmem_pkg::*;
#(
  parameter int LINES = 256
) (
  input  logic                     clk,
  input  logic [$clog2(LINES)-1:0] a_line_i,
  input  logic [LANES-1:0]         a_lane_we_i,
  input  logic [LINE_W-1:0]        a_wdata_i,
  output logic [LINE_W-1:0]        a_rdata_o,
  input  logic [$clog2(LINES)-1:0] b_line_i,
  input  logic                     b_we_i,
  input  logic [LINE_W-1:0]        b_wdata_i,
  output logic [LINE_W-1:0]        b_rdata_o
);

  logic [LINE_W-1:0] mem_q [LINES];
  logic [LINE_W-1:0] a_rdata_q;
  logic [LINE_W-1:0] b_rdata_q;

  // Reads sample the array before this edge's writes land (read-first).
  // The scalar lane writes are issued after the full-line write so they
  // take precedence when both sides hit the same line.
  always_ff @(posedge clk) begin
    a_rdata_q <= mem_q[a_line_i];
    b_rdata_q <= mem_q[b_line_i];
    if (b_we_i) begin
      mem_q[b_line_i] <= b_wdata_i;
    end
    for (int l = 0; l < LANES; l++) begin
      if (a_lane_we_i[l]) begin
        mem_q[a_line_i][l*WORD_W +: WORD_W] <= a_wdata_i[l*WORD_W +: WORD_W];
      end
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule : dmem_line_ram

// File: rtl/dmem_responder.sv
// Dual-port data memory for a core: 32-bit scalar port and 128-bit vector port over shared lines, zero-cleared after reset.
// Latency: 1 cycle read on both ports; ready rises LINES cycles after reset deassertion.
// Backpressure: none; accesses before ready are ignored and read back 0, out-of-range accesses flag addr_err.
//
// Ports:
//   clk, reset (sync, active-low)
//   a_addr/a_we/a_wdata -> a_rdata   scalar word port
//   b_addr/b_we/b_wdata -> b_rdata   vector line port
//   ready                            clear walk finished
//   addr_err                         one-cycle pulse after an out-of-range access
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int LINES = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       a_addr,
  input  logic              a_we,
  input  logic [31:0]       a_wdata,
  output logic [31:0]       a_rdata,
  input  logic [31:0]       b_addr,
  input  logic              b_we,
  input  logic [LINE_W-1:0] b_wdata,
  output logic [LINE_W-1:0] b_rdata,
  output logic              ready,
  output logic              addr_err
);

  localparam int LW = $clog2(LINES);

  state_e        state_q, state_d;
  logic [LW-1:0] clr_line_q, clr_line_d;

  logic          live;
  logic          a_oor, b_oor;
  logic [LW-1:0] a_line, b_line;

  logic [LANES-1:0]  ram_a_we;
  logic [LW-1:0]     ram_b_line;
  logic              ram_b_we;
  logic [LINE_W-1:0] ram_b_wdata;
  logic [LINE_W-1:0] ram_a_rdata;
  logic [LINE_W-1:0] ram_b_rdata;

  logic       a_ok_q, b_ok_q, err_q;
  logic [1:0] a_lane_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{a_addr[1:0], b_addr[3:0]};

  // ---------------- clear FSM ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= CLEAR;
      clr_line_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_line_q <= clr_line_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_line_d = clr_line_q;
    unique case (state_q)
      CLEAR: begin
        clr_line_d = clr_line_q + 1'b1;
        if (clr_line_q == LW'(LINES - 1)) begin
          state_d = READY;
        end
      end
      READY: begin
        state_d = READY;
      end
    endcase
  end

  // Ports only act when READY and reset is not being applied at this edge,
  // so an access sampled together with reset is aborted.
  assign live = reset && (state_q == READY);

  // ---------------- decode / range check ----------------
  assign a_oor  = (a_addr >> (LW + 4)) != 32'd0;
  assign b_oor  = (b_addr >> (LW + 4)) != 32'd0;
  assign a_line = a_addr[LW+3:4];
  assign b_line = b_addr[LW+3:4];

  assign ram_a_we = (live && a_we && !a_oor) ? (LANES'(1) << a_addr[3:2]) : '0;

  // The clear walk borrows the vector write port; port b traffic is
  // ignored during CLEAR anyway.
  always_comb begin
    ram_b_line  = b_line;
    ram_b_we    = live && b_we && !b_oor;
    ram_b_wdata = b_wdata;
    if (state_q == CLEAR) begin
      ram_b_line  = clr_line_q;
      ram_b_we    = reset;
      ram_b_wdata = '0;
    end
  end

  dmem_line_ram #(
    .LINES(LINES)
  ) u_ram (
    .clk        (clk),
    .a_line_i   (a_line),
    .a_lane_we_i(ram_a_we),
    .a_wdata_i  ({LANES{a_wdata}}),
    .a_rdata_o  (ram_a_rdata),
    .b_line_i   (ram_b_line),
    .b_we_i     (ram_b_we),
    .b_wdata_i  (ram_b_wdata),
    .b_rdata_o  (ram_b_rdata)
  );

  // ---------------- read qualification ----------------
  // The RAM output registers are not reset; these flags zero the visible
  // read data after reset, during CLEAR and for out-of-range reads.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_ok_q   <= 1'b0;
      b_ok_q   <= 1'b0;
      err_q    <= 1'b0;
      a_lane_q <= '0;
    end else begin
      a_ok_q   <= live && !a_oor;
      b_ok_q   <= live && !b_oor;
      err_q    <= live && (a_oor || b_oor);
      a_lane_q <= a_addr[3:2];
    end
  end

  assign a_rdata  = a_ok_q ? ram_a_rdata[a_lane_q*WORD_W +: WORD_W] : '0;
  assign b_rdata  = b_ok_q ? ram_b_rdata : '0;
  assign addr_err = err_q;
  assign ready    = (state_q == READY);

endmodule : dmem_responder

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int LINES = 256;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  a_addr;
  logic         a_we;
  logic [31:0]  a_wdata;
  logic [31:0]  a_rdata;
  logic [31:0]  b_addr;
  logic         b_we;
  logic [127:0] b_wdata;
  logic [127:0] b_rdata;
  logic         ready;
  logic         addr_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.LINES(LINES)) dut (
    .clk     (clk),
    .reset   (reset),
    .a_addr  (a_addr),
    .a_we    (a_we),
    .a_wdata (a_wdata),
    .a_rdata (a_rdata),
    .b_addr  (b_addr),
    .b_we    (b_we),
    .b_wdata (b_wdata),
    .b_rdata (b_rdata),
    .ready   (ready),
    .addr_err(addr_err)
  );

  // ---------------- reference model ----------------
  // Memory as an array of lines. Storage is only observable after the clear
  // walk, so the model simply zeroes everything whenever reset is sampled.
  logic [127:0] mem [LINES];
  int           since_rel = 0;   // edges sampled with reset high, saturating
  logic [31:0]  exp_a;
  logic [127:0] exp_b;
  logic         exp_err;
  logic         exp_rdy;

  task automatic model_edge();
    bit aok, bok;
    int al, bl, lane;
    if (!reset) begin
      since_rel = 0;
      foreach (mem[i]) mem[i] = '0;
      exp_a = '0; exp_b = '0; exp_err = 1'b0;
    end else begin
      if (since_rel >= LINES) begin
        aok  = a_addr < LINES * 16;
        bok  = b_addr < LINES * 16;
        al   = a_addr / 16;
        bl   = b_addr / 16;
        lane = (a_addr / 4) % 4;
        exp_a   = aok ? mem[al][lane*32 +: 32] : 32'h0;
        exp_b   = bok ? mem[bl] : 128'h0;
        exp_err = !aok || !bok;
        if (b_we && bok) mem[bl] = b_wdata;
        if (a_we && aok) mem[al][lane*32 +: 32] = a_wdata;
      end else begin
        exp_a = '0; exp_b = '0; exp_err = 1'b0;
      end
      if (since_rel < LINES) since_rel++;
    end
    exp_rdy = reset && (since_rel >= LINES);
  endtask

  // Drive one cycle of inputs, advance the model at the edge, and return
  // #1 after the edge so outputs can be sampled away from it.
  task automatic cycle(input logic rst, input logic [31:0] aa, input logic awe,
                       input logic [31:0] awd, input logic [31:0] ba,
                       input logic bwe, input logic [127:0] bwd);
    reset = rst; a_addr = aa; a_we = awe; a_wdata = awd;
    b_addr = ba; b_we = bwe; b_wdata = bwd;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [31:0] rand_addr(input bit allow_oor);
    logic [31:0] r;
    if (allow_oor && $urandom_range(0, 9) == 0)
      r = 32'h0000_1000 + ($urandom & 32'h0FFF_FFFF);
    else
      r = ($urandom_range(0, 7) << 4) | ($urandom & 32'hF);
    return r;
  endfunction

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- tests ----------------
  task automatic test_all_lines(input bit expect_zero);
    for (int l = 0; l < LINES; l++) begin
      cycle(1'b1, 32'(l*16 + (l%4)*4), 1'b0, 32'h0, 32'(l*16), 1'b0, 128'h0);
      total++;
      if (b_rdata !== exp_b) begin
        bad++; $display("FAIL sweep_b line %0d: got %h want %h", l, b_rdata, exp_b);
      end
      total++;
      if (a_rdata !== exp_a) begin
        bad++; $display("FAIL sweep_a line %0d: got %h want %h", l, a_rdata, exp_a);
      end
      if (expect_zero) begin
        total++;
        if (b_rdata !== 128'h0) begin
          bad++; $display("FAIL sweep_zero line %0d: got %h want 0", l, b_rdata);
        end
      end
    end
  endtask

  task automatic test_reset();
    int n = 0;
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 128'h0);
    total++;
    if (ready !== 1'b0 || a_rdata !== 32'h0 || b_rdata !== 128'h0 || addr_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got rdy=%b a=%h b=%h err=%b want all 0", ready, a_rdata, b_rdata, addr_err);
    end
    // Writes (and out-of-range addresses) hammered throughout CLEAR must be ignored.
    while (n < 300) begin
      cycle(1'b1, rand_addr(1), 1'b1, $urandom, rand_addr(1), 1'b1, rand_line());
      n++;
      total++;
      if (ready !== exp_rdy) begin
        bad++; $display("FAIL clear_ready cyc %0d: got %b want %b", n, ready, exp_rdy);
      end
      total++;
      if (a_rdata !== 32'h0 || b_rdata !== 128'h0 || addr_err !== 1'b0) begin
        bad++; $display("FAIL clear_outputs cyc %0d: got a=%h b=%h err=%b want 0", n, a_rdata, b_rdata, addr_err);
      end
      if (ready === 1'b1) break;
    end
    total++;
    if (n != LINES) begin
      bad++; $display("FAIL ready_latency: got %0d want %0d", n, LINES);
    end
    test_all_lines(1'b1);
  endtask

  task automatic test_scalar_write();
    cycle(1'b1, 32'h24, 1'b1, 32'hDEADBEEF, 32'h0, 1'b0, 128'h0);
    cycle(1'b1, 32'h0, 1'b0, 32'h0, 32'h20, 1'b0, 128'h0);
    // 0x24 selects lane 1, i.e. bits [63:32] of line 2.
    total++;
    if (b_rdata !== 128'h00000000_00000000_DEADBEEF_00000000) begin
      bad++; $display("FAIL scalar_lane: got %h want %h", b_rdata, 128'h00000000_00000000_DEADBEEF_00000000);
    end
    total++;
    if (b_rdata !== exp_b) begin
      bad++; $display("FAIL scalar_lane_model: got %h want %h", b_rdata, exp_b);
    end
  endtask

  task automatic test_collision();
    cycle(1'b1, 32'h38, 1'b1, 32'hCAFEF00D, 32'h30, 1'b1, {4{32'h11111111}});
    cycle(1'b1, 32'h38, 1'b0, 32'h0, 32'h30, 1'b0, 128'h0);
    total++;
    if (b_rdata !== 128'h11111111_CAFEF00D_11111111_11111111) begin
      bad++; $display("FAIL collision_merge: got %h want %h", b_rdata, 128'h11111111_CAFEF00D_11111111_11111111);
    end
    total++;
    if (a_rdata !== 32'hCAFEF00D) begin
      bad++; $display("FAIL collision_scalar: got %h want cafef00d", a_rdata);
    end
  endtask

  task automatic test_read_first();
    cycle(1'b1, 32'h40, 1'b1, 32'h5, 32'h40, 1'b0, 128'h0);
    total++;
    if (b_rdata !== 128'h0) begin
      bad++; $display("FAIL read_first_old: got %h want 0", b_rdata);
    end
    cycle(1'b1, 32'h0, 1'b0, 32'h0, 32'h40, 1'b0, 128'h0);
    total++;
    if (b_rdata !== 128'h5) begin
      bad++; $display("FAIL read_first_new: got %h want 5", b_rdata);
    end
  endtask

  task automatic test_out_of_range();
    // Line 0 gets a marker so a wrapped write to 0x1000 would be visible.
    cycle(1'b1, 32'h0, 1'b1, 32'h12345678, 32'h0, 1'b0, 128'h0);
    cycle(1'b1, 32'h1000, 1'b0, 32'h0, 32'h0, 1'b0, 128'h0);
    total++;
    if (a_rdata !== 32'h0 || addr_err !== 1'b1) begin
      bad++; $display("FAIL oor_read_a: got a=%h err=%b want a=0 err=1", a_rdata, addr_err);
    end
    cycle(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 128'h0);
    total++;
    if (addr_err !== 1'b0 || a_rdata !== 32'h12345678) begin
      bad++; $display("FAIL oor_pulse_end: got err=%b a=%h want err=0 a=12345678", addr_err, a_rdata);
    end
    cycle(1'b1, 32'h1000, 1'b1, 32'hBAD0BAD0, 32'h2000, 1'b1, {4{32'hFFFFFFFF}});
    total++;
    if (b_rdata !== 128'h0 || addr_err !== 1'b1) begin
      bad++; $display("FAIL oor_read_b: got b=%h err=%b want b=0 err=1", b_rdata, addr_err);
    end
    cycle(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 128'h0);
    total++;
    if (a_rdata !== 32'h12345678 || addr_err !== 1'b0) begin
      bad++; $display("FAIL oor_write_dropped: got a=%h err=%b want a=12345678 err=0", a_rdata, addr_err);
    end
    test_all_lines(1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(1'b1, rand_addr(1), 1'($urandom), $urandom, rand_addr(1), 1'($urandom), rand_line());
      total++;
      if (a_rdata !== exp_a) begin
        bad++; $display("FAIL rand_a cyc %0d: got %h want %h", i, a_rdata, exp_a);
      end
      total++;
      if (b_rdata !== exp_b) begin
        bad++; $display("FAIL rand_b cyc %0d: got %h want %h", i, b_rdata, exp_b);
      end
      total++;
      if (addr_err !== exp_err || ready !== 1'b1) begin
        bad++; $display("FAIL rand_err cyc %0d: got err=%b rdy=%b want err=%b rdy=1", i, addr_err, ready, exp_err);
      end
    end
  endtask

  task automatic test_reset_midburst();
    int n = 0;
    for (int i = 0; i < 20; i++)
      cycle(1'b1, rand_addr(0), 1'b1, $urandom, rand_addr(0), 1'b1, rand_line());
    cycle(1'b0, rand_addr(0), 1'b1, $urandom, rand_addr(0), 1'b1, rand_line());
    total++;
    if (ready !== 1'b0 || a_rdata !== 32'h0 || b_rdata !== 128'h0 || addr_err !== 1'b0) begin
      bad++;
      $display("FAIL midburst_reset: got rdy=%b a=%h b=%h err=%b want all 0", ready, a_rdata, b_rdata, addr_err);
    end
    while (n < 300) begin
      cycle(1'b1, rand_addr(0), 1'b1, $urandom, rand_addr(0), 1'b1, rand_line());
      n++;
      total++;
      if (ready !== exp_rdy) begin
        bad++; $display("FAIL midburst_ready cyc %0d: got %b want %b", n, ready, exp_rdy);
      end
      if (ready === 1'b1) break;
    end
    total++;
    if (n != LINES) begin
      bad++; $display("FAIL midburst_latency: got %0d want %0d", n, LINES);
    end
    test_all_lines(1'b1);
  endtask

  initial begin
    reset = 1'b0; a_addr = '0; a_we = 1'b0; a_wdata = '0;
    b_addr = '0; b_we = 1'b0; b_wdata = '0;
    test_reset();
    test_scalar_write();
    test_collision();
    test_read_first();
    test_out_of_range();
    test_random();
    test_reset_midburst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_dmem_responder
